// File: rtl/lfsr_gen.sv
// Galois LFSR pseudo-random word source with a valid/ready output stage, seed load and word counter.
// Optional feature: define LFSR_GEN_PERIOD_EN to add ref_seed tracking and the period_done pulse.
module lfsr_gen #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = 32'h0040_0007,
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}},
  parameter int               OUT_W = WIDTH,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             load_err,
  output logic [CNT_W-1:0] word_cnt,
  output logic             period_done
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e           fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] lfsr_nxt;
  logic             seed_zero;
  logic [WIDTH-1:0] load_seed;
  logic             accept;
  logic             capture;

  assign lfsr_nxt  = {lfsr_q[WIDTH-2:0], 1'b0} ^ (lfsr_q[WIDTH-1] ? POLY : '0);
  assign seed_zero = (seed_in == '0);
  assign load_seed = seed_zero ? SEED : seed_in;

  // A handshake in a load cycle is swallowed: it neither counts nor triggers a capture.
  assign accept  = !load && (fsm_q == ST_FULL) && out_ready;
  assign capture = !load && en && ((fsm_q == ST_EMPTY) || out_ready);

  always_comb begin
    fsm_d  = fsm_q;
    lfsr_d = lfsr_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    err_d  = 1'b0;
    if (load) begin
      lfsr_d = load_seed;
      fsm_d  = ST_EMPTY;
      cnt_d  = '0;
      err_d  = seed_zero;
    end else begin
      if (accept) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      unique case (fsm_q)
        ST_EMPTY: begin
          if (capture) begin
            data_d = lfsr_q[OUT_W-1:0];
            lfsr_d = lfsr_nxt;
            fsm_d  = ST_FULL;
          end
        end
        ST_FULL: begin
          if (capture) begin
            data_d = lfsr_q[OUT_W-1:0];
            lfsr_d = lfsr_nxt;
          end else if (accept) begin
            fsm_d = ST_EMPTY;
          end
        end
        default: fsm_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsm_q  <= ST_EMPTY;
      lfsr_q <= SEED;
      data_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      lfsr_q <= lfsr_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = (fsm_q == ST_FULL);
  assign load_err  = err_q;
  assign word_cnt  = cnt_q;

`ifdef LFSR_GEN_PERIOD_EN
  logic [WIDTH-1:0] ref_seed_q, ref_seed_d;
  logic             period_q, period_d;

  // The sequence has wrapped once a step lands back on the seed it started from.
  always_comb begin
    ref_seed_d = ref_seed_q;
    period_d   = 1'b0;
    if (load) begin
      ref_seed_d = load_seed;
    end else if (capture) begin
      period_d = (lfsr_nxt == ref_seed_q);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ref_seed_q <= SEED;
      period_q   <= 1'b0;
    end else begin
      ref_seed_q <= ref_seed_d;
      period_q   <= period_d;
    end
  end

  assign period_done = period_q;
`else
  assign period_done = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: randomized traffic on a 32-bit instance against a
// sequence-position model, plus 10-bit period and 4-bit period_done instances.
module tb_lfsr_gen;

  localparam logic [31:0] POLY32 = 32'h0040_0007;
  localparam logic [31:0] SEED32 = 32'hFFFF_FFFF;

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  // main 32-bit instance, small counter so wrap-around is exercised
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [31:0] seedIn = '0;
  logic        outReady = 1'b0;
  logic [31:0] outData;
  logic        outValid;
  logic        loadErr;
  logic [3:0]  wordCnt;
  logic        periodDone;

  // 10-bit instance
  logic        en10 = 1'b0;
  logic        ready10 = 1'b0;
  logic [9:0]  seed10 = '0;
  logic [9:0]  data10;
  logic        valid10;
  logic        err10;
  logic [15:0] cnt10;
  logic        per10;

  // 4-bit instance
  logic        en4 = 1'b0;
  logic        ready4 = 1'b0;
  logic [3:0]  seed4 = '0;
  logic [3:0]  data4;
  logic        valid4;
  logic        err4;
  logic [15:0] cnt4;
  logic        per4;

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(32), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .en(en), .load(load), .seed_in(seedIn),
    .out_data(outData), .out_valid(outValid), .out_ready(outReady),
    .load_err(loadErr), .word_cnt(wordCnt), .period_done(periodDone)
  );

  lfsr_gen #(.WIDTH(10), .POLY(10'h009), .SEED(10'h3FF)) dut10 (
    .clk(clk), .rstn(rstn), .en(en10), .load(1'b0), .seed_in(seed10),
    .out_data(data10), .out_valid(valid10), .out_ready(ready10),
    .load_err(err10), .word_cnt(cnt10), .period_done(per10)
  );

  lfsr_gen #(.WIDTH(4), .POLY(4'h3), .SEED(4'h1)) dut4 (
    .clk(clk), .rstn(rstn), .en(en4), .load(1'b0), .seed_in(seed4),
    .out_data(data4), .out_valid(valid4), .out_ready(ready4),
    .load_err(err4), .word_cnt(cnt4), .period_done(per4)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsrStep(input logic [31:0] s);
    logic [31:0] r;
    r = s << 1;
    if (s >= 32'h8000_0000) r = r ^ POLY32;
    return r;
  endfunction

  // Word number n of the stream started from seed is seed advanced n times.
  function automatic logic [31:0] nthWord(input logic [31:0] seed, input int n);
    logic [31:0] s;
    s = seed;
    for (int i = 0; i < n; i++) s = lfsrStep(s);
    return s;
  endfunction

  // Model: effective seed, words captured and words accepted since reset/load.
  logic [31:0] mSeed;
  int          mTaken;
  logic        mFull;
  int          mAccepted;
  logic        mErr;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mSeed     <= SEED32;
      mTaken    <= 0;
      mFull     <= 1'b0;
      mAccepted <= 0;
      mErr      <= 1'b0;
    end else if (load) begin
      mSeed     <= (seedIn == 32'd0) ? SEED32 : seedIn;
      mTaken    <= 0;
      mFull     <= 1'b0;
      mAccepted <= 0;
      mErr      <= (seedIn == 32'd0);
    end else begin
      mErr <= 1'b0;
      if (mFull && outReady) mAccepted <= mAccepted + 1;
      if (en && (!mFull || outReady)) begin
        mTaken <= mTaken + 1;
        mFull  <= 1'b1;
      end else if (mFull && outReady) begin
        mFull <= 1'b0;
      end
    end
  end

  logic cmpOn = 1'b0;

  always @(posedge clk) begin
    #2;
    if (cmpOn) begin
      checkOutput("out_valid", 64'(outValid), 64'(mFull));
      if (mFull) checkOutput("out_data", 64'(outData), 64'(nthWord(mSeed, mTaken - 1)));
      checkOutput("word_cnt", 64'(wordCnt), 64'(mAccepted % 16));
      checkOutput("load_err", 64'(loadErr), 64'(mErr));
      checkOutput("period_done32", 64'(periodDone), 64'd0);
    end
  end

  task automatic applyStimulus(input logic e, input logic r, input logic l, input logic [31:0] s);
    @(negedge clk);
    en = e;
    outReady = r;
    load = l;
    seedIn = s;
  endtask

  task automatic sampleCycle();
    @(posedge clk);
    #2;
  endtask

  logic [9:0] words10 [1024];
  bit         seen10 [1024];
  int         distinct10;
  logic       prevLoad;

  initial begin
    $display("[TB] start");
    repeat (2) @(posedge clk);
    #2;
    cmpOn = 1'b1;
    checkOutput("reset_valid", 64'(outValid), 64'd0);
    checkOutput("reset_data", 64'(outData), 64'd0);
    checkOutput("reset_cnt", 64'(wordCnt), 64'd0);
    checkOutput("reset_err", 64'(loadErr), 64'd0);

    @(negedge clk);
    rstn = 1'b1;
    en = 1'b1;
    outReady = 1'b1;
    sampleCycle();
    checkOutput("first_valid", 64'(outValid), 64'd1);
    checkOutput("word0", 64'(outData), 64'hFFFF_FFFF);
    sampleCycle();
    checkOutput("word1", 64'(outData), 64'hFFBF_FFF9);
    sampleCycle();
    checkOutput("word2", 64'(outData), 64'hFF3F_FFF5);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      sampleCycle();
      checkOutput("stall_data", 64'(outData), 64'hFF3F_FFF5);
      checkOutput("stall_cnt", 64'(wordCnt), 64'd2);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    sampleCycle();
    checkOutput("resume_word3", 64'(outData), 64'hFE3F_FFED);
    checkOutput("resume_cnt", 64'(wordCnt), 64'd3);

    applyStimulus(1'b1, 1'b1, 1'b1, 32'd0);
    sampleCycle();
    checkOutput("zload_valid", 64'(outValid), 64'd0);
    checkOutput("zload_err", 64'(loadErr), 64'd1);
    checkOutput("zload_cnt", 64'(wordCnt), 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    sampleCycle();
    checkOutput("zload_word", 64'(outData), 64'hFFFF_FFFF);
    checkOutput("zload_err_clr", 64'(loadErr), 64'd0);

    applyStimulus(1'b1, 1'b1, 1'b1, 32'h1234_5678);
    sampleCycle();
    checkOutput("load_err_nz", 64'(loadErr), 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    sampleCycle();
    checkOutput("load_word", 64'(outData), 64'h1234_5678);

    prevLoad = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      logic l;
      l = !prevLoad && ($urandom_range(0, 39) == 0);
      prevLoad = l;
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, l,
                    ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom());
      sampleCycle();
      if (c % 500 == 250) begin
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("async_reset_valid", 64'(outValid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        prevLoad = 1'b0;
      end
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    en10 = 1'b1;
    ready10 = 1'b1;
    en4 = 1'b1;
    ready4 = 1'b1;
    for (int k = 1; k <= 1024; k++) begin
      sampleCycle();
      words10[k-1] = data10;
      if (k <= 30) begin
`ifdef LFSR_GEN_PERIOD_EN
        checkOutput("period_done4", 64'(per4), 64'(k == 15));
`else
        checkOutput("period_done4_off", 64'(per4), 64'd0);
`endif
      end
      if (k == 1) begin
        checkOutput("w10_valid", 64'(valid10), 64'd1);
        checkOutput("w4_word0", 64'(data4), 64'h1);
      end
      if (k == 2) checkOutput("w4_word1", 64'(data4), 64'h2);
    end
    checkOutput("w10_word0", 64'(words10[0]), 64'h3FF);
    checkOutput("w10_word1", 64'(words10[1]), 64'h3F7);
    distinct10 = 0;
    for (int i = 0; i < 1024; i++) seen10[i] = 1'b0;
    for (int i = 0; i < 1023; i++) begin
      if (!seen10[words10[i]]) distinct10++;
      seen10[words10[i]] = 1'b1;
    end
    checkOutput("w10_distinct", 64'(distinct10), 64'd1023);
    checkOutput("w10_zero_absent", 64'(seen10[0]), 64'd0);
    checkOutput("w10_repeat", 64'(words10[1023]), 64'(words10[0]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
